// File: rtl/fetchstage.sv
// Instruction fetch stage: issues word fetches at pc, inserts NOP bubbles on stalls,
// parks in FLUSH_WAIT after a control-flow word until it is resolved, and stops on HALT.
module fetchstage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready,
    input  logic        bus_yield,
    input  logic        pc_load,
    input  logic        pc_continue,
    input  logic [31:0] new_pc,
    output logic        fetch_read,
    output logic [31:0] fetch_address,
    output logic [31:0] outbound_instruction,
    output logic [31:0] outbound_pc,
    output logic        halted
);

    localparam logic [4:0] OPCODE_NOP    = 5'h00;
    localparam logic [4:0] OPCODE_BRANCH = 5'h10;
    localparam logic [4:0] OPCODE_JUMP   = 5'h11;
    localparam logic [4:0] OPCODE_HALT   = 5'h1F;

    localparam logic [1:0] RUNNING    = 2'd0;
    localparam logic [1:0] FLUSH_WAIT = 2'd1;
    localparam logic [1:0] HALTED     = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_p0;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic        accept;
    logic [4:0]  opcode;

    function automatic logic [31:0] nop_word();
        return {OPCODE_NOP, 27'h0};
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Reset is folded in so no request leaves while the stage is being reset.
    assign fetch_read    = (state == RUNNING) && !bus_yield && !reset;
    assign fetch_address = word_align(pc_p0);
    assign accept        = fetch_read && mem_ready;
    assign opcode        = mem_data_in[31:27];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUNNING;
            pc_p0    <= word_align(RESET_PC);
            instr_p1 <= nop_word();
            pc_p1    <= RESET_PC;
        end else begin
            // ---- stage p0 -> p1: latch fetched word or emit a bubble ----
            case (state)
                RUNNING: begin
                    if (accept) begin
                        instr_p1 <= mem_data_in;
                        pc_p1    <= pc_p0;
                        pc_p0    <= pc_p0 + 32'd4;
                        if (opcode == OPCODE_BRANCH || opcode == OPCODE_JUMP) begin
                            state <= FLUSH_WAIT;
                        end else if (opcode == OPCODE_HALT) begin
                            state <= HALTED;
                        end
                    end else begin
                        instr_p1 <= nop_word();
                    end
                end
                FLUSH_WAIT: begin
                    instr_p1 <= nop_word();
                    // A taken target wins over not-taken; pc already points past the branch.
                    if (pc_load) begin
                        pc_p0 <= word_align(new_pc);
                        state <= RUNNING;
                    end else if (pc_continue) begin
                        state <= RUNNING;
                    end
                end
                HALTED: begin
                    instr_p1 <= nop_word();
                end
                default: begin
                    instr_p1 <= nop_word();
                    state    <= RUNNING;
                end
            endcase
        end
    end

    assign outbound_instruction = instr_p1;
    assign outbound_pc          = pc_p1;
    assign halted               = (state == HALTED);

endmodule

// File: tb/tb_fetchstage.sv
// Directed plus randomized bench for fetchstage, checked against a cycle-level
// behavioural model of the fetch rules.
module tb_fetchstage;

    localparam logic [4:0] OP_NOP    = 5'h00;
    localparam logic [4:0] OP_ALU    = 5'h01;
    localparam logic [4:0] OP_BRANCH = 5'h10;
    localparam logic [4:0] OP_JUMP   = 5'h11;
    localparam logic [4:0] OP_HALT   = 5'h1F;
    localparam logic [31:0] NOP_W    = {OP_NOP, 27'h0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_data_in = '0;
    logic        mem_ready = 1'b0;
    logic        bus_yield = 1'b0;
    logic        pc_load = 1'b0;
    logic        pc_continue = 1'b0;
    logic [31:0] new_pc = '0;
    logic        fetch_read;
    logic [31:0] fetch_address;
    logic [31:0] outbound_instruction;
    logic [31:0] outbound_pc;
    logic        halted;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ins = NOP_W;
    logic [31:0] m_opc = 32'h0;
    bit          m_wait = 1'b0;
    bit          m_stop = 1'b0;

    fetchstage #(.RESET_PC(32'h00000000)) dut (
        .clock(clock),
        .reset(reset),
        .mem_data_in(mem_data_in),
        .mem_ready(mem_ready),
        .bus_yield(bus_yield),
        .pc_load(pc_load),
        .pc_continue(pc_continue),
        .new_pc(new_pc),
        .fetch_read(fetch_read),
        .fetch_address(fetch_address),
        .outbound_instruction(outbound_instruction),
        .outbound_pc(outbound_pc),
        .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [4:0] op);
        return {op, 27'($urandom)};
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registers.
    task automatic step(input bit rst, input bit rdy, input bit yld, input bit ld,
                        input bit cont, input logic [31:0] npc, input logic [31:0] data);
        bit exp_rd;
        @(negedge clock);
        reset = rst; mem_ready = rdy; bus_yield = yld; pc_load = ld;
        pc_continue = cont; new_pc = npc; mem_data_in = data;
        #1;
        exp_rd = !rst && !m_wait && !m_stop && !yld;
        chk("fetch_read", {31'h0, fetch_read}, {31'h0, exp_rd});
        if (!rst) chk("fetch_address", fetch_address, m_pc);
        @(posedge clock);
        if (rst) begin
            m_pc = 32'h0; m_wait = 0; m_stop = 0; m_ins = NOP_W; m_opc = 32'h0;
        end else if (m_stop) begin
            m_ins = NOP_W;
        end else if (m_wait) begin
            m_ins = NOP_W;
            if (ld) begin
                m_pc = npc & 32'hFFFF_FFFC; m_wait = 0;
            end else if (cont) begin
                m_wait = 0;
            end
        end else if (!yld && rdy) begin
            m_ins = data; m_opc = m_pc; m_pc = m_pc + 32'd4;
            if (data[31:27] == OP_BRANCH || data[31:27] == OP_JUMP) m_wait = 1;
            if (data[31:27] == OP_HALT) m_stop = 1;
        end else begin
            m_ins = NOP_W;
        end
        #1;
        chk("outbound_instruction", outbound_instruction, m_ins);
        chk("outbound_pc", outbound_pc, m_opc);
        chk("halted", {31'h0, halted}, {31'h0, m_stop});
    endtask

    task automatic run(input logic [31:0] data);
        step(0, 1, 0, 0, 0, 32'h0, data);
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 32'h0, word(OP_ALU));
    endtask

    initial begin
        logic [4:0] op;
        // Reset
        step(1, 1, 0, 1, 1, 32'h0, word(OP_ALU));
        step(1, 1, 0, 0, 0, 32'h0, word(OP_ALU));
        chk("reset_instr", outbound_instruction, NOP_W);
        chk("reset_pc", outbound_pc, 32'h0);
        chk("reset_addr", fetch_address, 32'h0);

        // Straight-line
        run(word(OP_ALU)); chk("straight_pc0", outbound_pc, 32'h0);
        run(word(OP_ALU)); chk("straight_pc4", outbound_pc, 32'h4);
        run(word(OP_ALU)); chk("straight_pc8", outbound_pc, 32'h8);

        // Bus yield: mem_ready high during yield must be ignored
        step(0, 1, 1, 0, 0, 32'h0, word(OP_ALU));
        step(0, 1, 1, 0, 0, 32'h0, word(OP_ALU));
        chk("yield_nop", outbound_instruction, NOP_W);
        chk("yield_addr", fetch_address, 32'hC);
        run(word(OP_ALU));

        // Taken branch at 16
        run(word(OP_BRANCH));
        idle(); idle(); idle();
        step(0, 1, 0, 1, 0, 32'h00000103, word(OP_ALU));
        chk("taken_addr", fetch_address, 32'h100);

        // Not-taken jump, then simultaneous load/continue
        run(word(OP_JUMP));
        idle();
        step(0, 1, 0, 0, 1, 32'h0, word(OP_ALU));
        chk("not_taken_addr", fetch_address, 32'h104);
        run(word(OP_BRANCH));
        step(0, 1, 0, 1, 1, 32'h40, word(OP_ALU));
        chk("load_priority_addr", fetch_address, 32'h40);

        // pc_load/pc_continue ignored while running
        step(0, 1, 0, 1, 1, 32'h800, word(OP_ALU));
        chk("load_ignored_addr", fetch_address, 32'h44);

        // Wrap and stall
        run(word(OP_BRANCH));
        step(0, 1, 0, 1, 0, 32'hFFFFFFFF, word(OP_ALU));
        step(0, 0, 0, 0, 0, 32'h0, word(OP_ALU));
        chk("stall_nop", outbound_instruction, NOP_W);
        run(word(OP_ALU));
        chk("wrap_outpc", outbound_pc, 32'hFFFFFFFC);
        chk("wrap_addr", fetch_address, 32'h0);

        // HALT
        run(word(OP_HALT));
        chk("halt_word_op", {27'h0, outbound_instruction[31:27]}, {27'h0, OP_HALT});
        step(0, 1, 0, 1, 1, 32'h80, word(OP_ALU));
        step(0, 1, 0, 0, 0, 32'h0, word(OP_ALU));
        chk("halted_nop", outbound_instruction, NOP_W);
        chk("halted_flag", {31'h0, halted}, 32'h1);
        step(1, 1, 0, 0, 0, 32'h0, word(OP_ALU));
        chk("halt_reset_addr", fetch_address, 32'h0);
        chk("halt_reset_flag", {31'h0, halted}, 32'h0);

        // Reset mid-FLUSH_WAIT
        run(word(OP_ALU));
        run(word(OP_BRANCH));
        step(1, 1, 0, 1, 0, 32'h200, word(OP_ALU));
        chk("flush_reset_addr", fetch_address, 32'h0);
        run(word(OP_ALU));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 31))
                0, 1, 2:    op = OP_BRANCH;
                3, 4:       op = OP_JUMP;
                5:          op = OP_HALT;
                6:          op = OP_NOP;
                default:    op = OP_ALU;
            endcase
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom, word(op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetchstage.md
FETCHSTAGE -- requirements
Module: fetchstage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning first instruction address after reset (word aligned).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_data_in  input  32  instruction word from bus interface.
REQ-005 SHALL have port mem_ready  input  1  mem_data_in valid this cycle for the outstanding fetch.
REQ-006 SHALL have port bus_yield  input  1  downstream stage owns the bus this cycle (driven from its memory_access_cycle).
REQ-007 SHALL have port pc_load  input  1  control-flow resolved as taken; new_pc is the target.
REQ-008 SHALL have port pc_continue  input  1  control-flow resolved as not taken.
REQ-009 SHALL have port new_pc  input  32  target address, qualified by pc_load.
REQ-010 SHALL have port fetch_read  output  1  fetch request to bus interface.
REQ-011 SHALL have port fetch_address  output  32  byte address of fetch (current pc).
REQ-012 SHALL have port outbound_instruction  output  32  instruction to downstream stage's inbound_instruction.
REQ-013 SHALL have port outbound_pc  output  32  address of outbound_instruction.
REQ-014 SHALL have port halted  output  1  fetch permanently stopped by HALT.

Function
REQ-015 SHALL keep a 32-bit pc register and a state register with states RUNNING, FLUSH_WAIT, HALTED.
REQ-016 SHALL drive fetch_address = pc with bits [1:0] always 0; fetch_read = 1 only when state is RUNNING and bus_yield is 0 (combinational from state and bus_yield).
REQ-017 In RUNNING, if fetch_read is 1 and mem_ready is 1 at posedge: outbound_instruction <= mem_data_in, outbound_pc <= pc, pc <= pc + 4 (modulo 2^32; 32'hFFFFFFFC wraps to 0).
REQ-018 In RUNNING, if bus_yield is 1 or mem_ready is 0 at posedge: outbound_instruction <= { OPCODE_NOP, 27'h0 }, pc held, state held (bubble insertion; one NOP per yielded or unready cycle).
REQ-019 mem_ready while bus_yield is 1 SHALL be ignored (data belongs to downstream access).
REQ-020 On a latched word whose opcode [31:27] is OPCODE_BRANCH or OPCODE_JUMP, the word SHALL be passed downstream unchanged and state SHALL become FLUSH_WAIT at the same edge.
REQ-021 On a latched word whose opcode is OPCODE_HALT, the word SHALL be passed downstream and state SHALL become HALTED at the same edge.
REQ-022 In FLUSH_WAIT: no fetches; outbound_instruction <= NOP every cycle; pc_load=1 -> pc <= { new_pc[31:2], 2'b00 }, state <= RUNNING; else pc_continue=1 -> pc unchanged (already incremented), state <= RUNNING; neither -> remain.
REQ-023 pc_load SHALL take priority over pc_continue when both are 1; both SHALL be ignored outside FLUSH_WAIT.
REQ-024 In HALTED: no fetches, outbound_instruction <= NOP every cycle, halted = 1, pc held; exit only by reset.
REQ-025 First fetch after leaving FLUSH_WAIT SHALL be issued in the cycle immediately following the resolving edge (one-cycle minimum restart latency).
REQ-026 Latency: instruction appears on outbound_instruction the cycle after the edge where mem_ready was sampled high.

Reset
REQ-027 With reset=1 at posedge: pc <= RESET_PC, state <= RUNNING, outbound_instruction <= { OPCODE_NOP, 27'h0 }, outbound_pc <= RESET_PC, halted <= 0; reset overrides all other inputs, including mid-FLUSH_WAIT and HALTED.
REQ-028 While reset is 1, fetch_read SHALL be 0.

Verification
REQ-029 Straight-line: reset, mem_ready=1 constant, ALU words at 0,4,8 -> outbound_pc 0,4,8 on successive cycles, fetch_address 0,4,8,12.
REQ-030 Bus yield: bus_yield=1 for 2 cycles after fetch at 8 -> fetch_read=0 two cycles, two NOPs emitted, next fetch at 12 with pc unaltered.
REQ-031 Taken branch: BRANCH word at 16, then 3 idle cycles, pc_load=1 new_pc=32'h00000103 -> 3+ NOPs, no fetches during wait, next fetch_address 32'h00000100.
REQ-032 Not-taken: JUMP/BRANCH at 20, pc_continue=1 two cycles later -> next fetch_address 24; simultaneous pc_load=1 new_pc=32'h40 -> fetch_address 32'h40.
REQ-033 HALT at 28 -> HALT word emitted, halted=1 next cycle, NOPs forever, fetch_read=0; reset -> fetch_address RESET_PC, halted=0.
REQ-034 Wrap and stall: pc=32'hFFFFFFFC, mem_ready=0 for 1 cycle then 1 -> one NOP, then outbound_pc 32'hFFFFFFFC, next fetch_address 0.
